// File: rtl/stream_mux_rr.sv
// ============================================================================
// Module   : stream_mux_rr
// Brief    : N-input valid/ready stream multiplexer with a registered output
//            stage. Arbitration is round-robin (RR_MODE=1) or an external
//            channel select (RR_MODE=0). One beat per cycle throughput.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_mux_rr #(
  parameter  int N_IN    = 4,
  parameter  int WIDTH   = 4,
  parameter  int RR_MODE = 1,
  localparam int SW      = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN-1:0]       in_valid,
  input  logic [N_IN*WIDTH-1:0] in_data,
  output logic [N_IN-1:0]       in_ready,
  input  logic [SW-1:0]         sel,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SW-1:0]         out_src,
  input  logic                  out_ready
);

  // Output register and round-robin pointer
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SW-1:0]    out_src_q,   out_src_d;
  logic [SW-1:0]    ptr_q,       ptr_d;

  // Arbitration results
  logic [N_IN-1:0]  rr_mask;
  logic [N_IN-1:0]  rr_hi_req;
  logic             rr_hi_found, rr_lo_found;
  logic [SW-1:0]    rr_hi_idx,   rr_lo_idx;
  logic             sel_found;
  logic [SW-1:0]    sel_idx;
  logic             grant_vld;
  logic [SW-1:0]    grant_idx;
  logic [WIDTH-1:0] grant_data;
  logic             load_en;
  logic             in_xfer;

  // The register can accept a new beat when empty or when it drains this cycle
  assign load_en = !out_valid_q || out_ready;

  // Round-robin: first valid channel at or above ptr, else first valid overall
  always_comb begin
    rr_mask     = '0;
    rr_hi_req   = '0;
    rr_hi_found = 1'b0;
    rr_lo_found = 1'b0;
    rr_hi_idx   = '0;
    rr_lo_idx   = '0;
    for (int i = 0; i < N_IN; i++) begin
      rr_mask[i] = (SW'(i) >= ptr_q);
    end
    rr_hi_req = in_valid & rr_mask;
    // Descending scan so the lowest matching index is the one that sticks
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (rr_hi_req[i]) begin
        rr_hi_found = 1'b1;
        rr_hi_idx   = SW'(i);
      end
      if (in_valid[i]) begin
        rr_lo_found = 1'b1;
        rr_lo_idx   = SW'(i);
      end
    end
  end

  // External select: grant only a legal, valid channel; out-of-range sel never matches
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < N_IN; i++) begin
      if ((sel == SW'(i)) && in_valid[i]) begin
        sel_found = 1'b1;
        sel_idx   = SW'(i);
      end
    end
  end

  // Pick the arbitration result for the configured mode and mux the winner's data
  always_comb begin
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
    if (RR_MODE != 0) begin
      grant_vld = rr_lo_found;
      grant_idx = rr_hi_found ? rr_hi_idx : rr_lo_idx;
    end else begin
      grant_vld = sel_found;
      grant_idx = sel_idx;
    end
    for (int i = 0; i < N_IN; i++) begin
      if (grant_idx == SW'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // One-hot ready toward the granted channel; forced low while reset is held
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_IN; i++) begin
      in_ready[i] = rst_n && load_en && grant_vld && (grant_idx == SW'(i));
    end
  end

  assign in_xfer = |in_ready;

  // Next state of output register and pointer
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      out_valid_d = in_xfer;
    end
    if (in_xfer) begin
      out_data_d = grant_data;
      out_src_d  = grant_idx;
      if (RR_MODE != 0) begin
        ptr_d = (grant_idx == SW'(N_IN - 1)) ? '0 : grant_idx + SW'(1);
      end
    end
    if (RR_MODE == 0) begin
      ptr_d = '0;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

`default_nettype wire
